// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and helpers for the dmem port arbiter slice.
package dmem_port_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_LEN_DEFAULT = 8;
  localparam int unsigned WMASK_W               = 4;
  localparam int unsigned WORD_W                = 32;

  localparam logic CSB_ACTIVE = 1'b0;
  localparam logic CSB_IDLE   = 1'b1;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr_i, with wrap-around.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] k;
    found = 1'b0;
    sum   = '0;
    k     = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      k = sum[IDX_W-1:0];
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the 1W/1R dmem between NUM_REQ requesters with independent round-robin
// write and read arbitration; read responses return one cycle after grant.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned DMEM_ADDR_LEN = DMEM_ADDR_LEN_DEFAULT
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NUM_REQ-1:0]                wr_valid_i,
  output logic [NUM_REQ-1:0]                wr_ready_o,
  input  logic [NUM_REQ*DMEM_ADDR_LEN-1:0]  wr_addr_i,
  input  logic [NUM_REQ*WMASK_W-1:0]        wr_mask_i,
  input  logic [NUM_REQ*WORD_W-1:0]         wr_data_i,
  input  logic [NUM_REQ-1:0]                rd_valid_i,
  output logic [NUM_REQ-1:0]                rd_ready_o,
  input  logic [NUM_REQ*DMEM_ADDR_LEN-1:0]  rd_addr_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [WORD_W-1:0]                 rsp_data_o,
  output logic                              dmem_csb_write_o,
  output logic [WMASK_W-1:0]                dmem_wmask_o,
  output logic [DMEM_ADDR_LEN-1:0]          dmem_waddr_o,
  output logic [WORD_W-1:0]                 dmem_din_o,
  output logic                              dmem_csb_read_o,
  output logic [DMEM_ADDR_LEN-1:0]          dmem_raddr_o,
  input  logic [WORD_W-1:0]                 dmem_dout_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0] pend_id_q, pend_id_d;

  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic               wr_any, rd_any;

  logic [DMEM_ADDR_LEN-1:0] wr_addr_win, rd_addr_win;
  logic [WMASK_W-1:0]       wr_mask_win;
  logic [WORD_W-1:0]        wr_data_win;
  logic                     wr_go, rd_go, conflict;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_wr_pick (
    .req_i (wr_valid_i),
    .ptr_i (wr_ptr_q),
    .gnt_o (wr_gnt),
    .idx_o (wr_idx),
    .any_o (wr_any)
  );

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rd_pick (
    .req_i (rd_valid_i),
    .ptr_i (rd_ptr_q),
    .gnt_o (rd_gnt),
    .idx_o (rd_idx),
    .any_o (rd_any)
  );

  // One-hot muxes selecting the winners' slices.
  always_comb begin
    wr_addr_win = '0;
    wr_mask_win = '0;
    wr_data_win = '0;
    rd_addr_win = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (wr_gnt[k]) begin
        wr_addr_win = wr_addr_i[k*DMEM_ADDR_LEN +: DMEM_ADDR_LEN];
        wr_mask_win = wr_mask_i[k*WMASK_W +: WMASK_W];
        wr_data_win = wr_data_i[k*WORD_W +: WORD_W];
      end
      if (rd_gnt[k]) rd_addr_win = rd_addr_i[k*DMEM_ADDR_LEN +: DMEM_ADDR_LEN];
    end
  end

  // Grants are gated by reset so every output is idle while reset_i is low.
  // A read hitting the word being written this cycle waits one cycle to see the new data.
  always_comb begin
    wr_go    = reset_i & wr_any;
    conflict = wr_go & rd_any & (rd_addr_win == wr_addr_win);
    rd_go    = reset_i & rd_any & ~conflict;

    wr_ready_o       = wr_go ? wr_gnt : '0;
    dmem_csb_write_o = wr_go ? CSB_ACTIVE : CSB_IDLE;
    dmem_waddr_o     = wr_go ? wr_addr_win : '0;
    dmem_wmask_o     = wr_go ? wr_mask_win : '0;
    dmem_din_o       = wr_go ? wr_data_win : '0;

    rd_ready_o       = rd_go ? rd_gnt : '0;
    dmem_csb_read_o  = rd_go ? CSB_ACTIVE : CSB_IDLE;
    dmem_raddr_o     = rd_go ? rd_addr_win : '0;

    wr_ptr_d     = wr_go ? IDX_W'(rr_next(32'(wr_idx), NUM_REQ)) : wr_ptr_q;
    rd_ptr_d     = rd_go ? IDX_W'(rr_next(32'(rd_idx), NUM_REQ)) : rd_ptr_q;
    pend_valid_d = rd_go;
    pend_id_d    = rd_go ? rd_idx : pend_id_q;
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (pend_valid_q) begin
      rsp_valid_o[pend_id_q] = 1'b1;
      rsp_data_o             = dmem_dout_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural 1W/1R SRAM.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset_i;
  logic [1:0]  wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_mask;
  logic [63:0] wr_data;
  logic [31:0] rsp_data, din, dout;
  logic        csb_w, csb_r;
  logic [3:0]  wmask;
  logic [7:0]  waddr, raddr;

  int n_cmp = 0;
  int n_mis = 0;

  dmem_port_arbiter #(.NUM_REQ(2), .DMEM_ADDR_LEN(8)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .wr_valid_i       (wr_valid),
    .wr_ready_o       (wr_ready),
    .wr_addr_i        (wr_addr),
    .wr_mask_i        (wr_mask),
    .wr_data_i        (wr_data),
    .rd_valid_i       (rd_valid),
    .rd_ready_o       (rd_ready),
    .rd_addr_i        (rd_addr),
    .rsp_valid_o      (rsp_valid),
    .rsp_data_o       (rsp_data),
    .dmem_csb_write_o (csb_w),
    .dmem_wmask_o     (wmask),
    .dmem_waddr_o     (waddr),
    .dmem_din_o       (din),
    .dmem_csb_read_o  (csb_r),
    .dmem_raddr_o     (raddr),
    .dmem_dout_i      (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: preload, then per edge capture read data before applying the write.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[8'h10] = 32'hDEADBEEF;
    dout = '0;
    forever begin
      @(posedge clk);
      if (csb_r === 1'b0) dout <= mem[raddr];
      if (csb_w === 1'b0)
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[waddr][8*b +: 8] = din[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i  = 1'b0;
    wr_valid = 2'b11;
    rd_valid = 2'b11;
    wr_addr  = {8'h02, 8'h01};
    rd_addr  = {8'h04, 8'h03};
    wr_mask  = 8'hFF;
    wr_data  = {32'hB1B1B1B1, 32'hA0A0A0A0};

    // Reset held with all valids high
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_rd_ready", 32'(rd_ready), 32'h0);
    chk("rst_csb_w", 32'(csb_w), 32'h1);
    chk("rst_csb_r", 32'(csb_r), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_waddr", 32'(waddr), 32'h0);
    chk("rst_din", din, 32'h0);

    // Release: requester 0 wins both ports
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("rel_wr_ready", 32'(wr_ready), 32'h1);
    chk("rel_rd_ready", 32'(rd_ready), 32'h1);
    chk("rel_waddr", 32'(waddr), 32'h01);
    chk("rel_din", din, 32'hA0A0A0A0);
    chk("rel_raddr", 32'(raddr), 32'h03);

    // Requester 1 reads 0x10; first response (addr 3) arrives
    @(negedge clk);
    wr_valid = 2'b00;
    rd_valid = 2'b10;
    rd_addr  = {8'h10, 8'h03};
    #1;
    chk("rsp0_valid", 32'(rsp_valid), 32'h1);
    chk("rsp0_data", rsp_data, 32'hC0DE0003);
    chk("lat_rd_ready", 32'(rd_ready), 32'h2);
    chk("lat_raddr", 32'(raddr), 32'h10);
    chk("lat_csb_w_idle", 32'(csb_w), 32'h1);

    @(negedge clk);
    rd_valid = 2'b00;
    #1;
    chk("lat_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("lat_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("lat_rd_idle", 32'(rd_ready), 32'h0);
    chk("lat_csb_r_idle", 32'(csb_r), 32'h1);

    // Read granted, then reset before the response edge
    @(negedge clk);
    rd_valid = 2'b01;
    rd_addr  = {8'h10, 8'h10};
    #1;
    chk("mid_rd_ready", 32'(rd_ready), 32'h1);
    #2;
    reset_i  = 1'b0;
    rd_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rsp_data", rsp_data, 32'h0);

    // Release into continuous writes from both; wr_ptr was 1 before reset
    @(negedge clk);
    reset_i  = 1'b1;
    wr_valid = 2'b11;
    wr_addr  = {8'h31, 8'h30};
    wr_mask  = 8'hFF;
    rd_valid = 2'b11;
    rd_addr  = {8'h41, 8'h40};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      wr_data = {32'h60000000 + 32'(i), 32'h50000000 + 32'(i)};
      if (i == 1) rd_valid = 2'b00;
      #1;
      chk("rr_wr_ready", 32'(wr_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_din", din, (i % 2 == 0) ? 32'h50000000 + 32'(i) : 32'h60000000 + 32'(i));
      if (i == 0) begin
        chk("post_rst_rsp", 32'(rsp_valid), 32'h0);
        chk("post_rst_rd_ready", 32'(rd_ready), 32'h1);
      end
      if (i == 1) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rr_rsp_data", rsp_data, 32'hC0DE0040);
      end
    end

    // Lone requester 1
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_valid = 2'b10;
      #1;
      chk("lone_wr_ready", 32'(wr_ready), 32'h2);
      chk("lone_waddr", 32'(waddr), 32'h31);
    end

    // Conflict: write 0x20 by req0 and read 0x20 by req1
    @(negedge clk);
    wr_valid = 2'b01;
    wr_addr  = {8'h31, 8'h20};
    wr_mask  = 8'h0F;
    wr_data  = {32'h0, 32'h12345678};
    rd_valid = 2'b10;
    rd_addr  = {8'h20, 8'h40};
    #1;
    chk("cf_wr_ready", 32'(wr_ready), 32'h1);
    chk("cf_rd_ready", 32'(rd_ready), 32'h0);
    chk("cf_csb_r", 32'(csb_r), 32'h1);
    chk("cf_csb_w", 32'(csb_w), 32'h0);
    chk("cf_waddr", 32'(waddr), 32'h20);
    chk("cf_wmask", 32'(wmask), 32'hF);

    @(negedge clk);
    wr_valid = 2'b00;
    #1;
    chk("cf_retry_ready", 32'(rd_ready), 32'h2);
    chk("cf_retry_raddr", 32'(raddr), 32'h20);
    chk("cf_no_rsp", 32'(rsp_valid), 32'h0);

    @(negedge clk);
    rd_valid = 2'b00;
    #1;
    chk("cf_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("cf_rsp_data", rsp_data, 32'h12345678);

    // Different addresses in the same cycle
    @(negedge clk);
    wr_valid = 2'b01;
    wr_addr  = {8'h31, 8'h21};
    wr_data  = {32'h0, 32'hCAFEF00D};
    rd_valid = 2'b10;
    rd_addr  = {8'h22, 8'h40};
    #1;
    chk("da_wr_ready", 32'(wr_ready), 32'h1);
    chk("da_rd_ready", 32'(rd_ready), 32'h2);
    chk("da_csb_w", 32'(csb_w), 32'h0);
    chk("da_csb_r", 32'(csb_r), 32'h0);
    chk("da_waddr", 32'(waddr), 32'h21);
    chk("da_raddr", 32'(raddr), 32'h22);

    // Zero-mask write from req1 to 0x22 is still granted
    @(negedge clk);
    wr_valid = 2'b10;
    wr_addr  = {8'h22, 8'h21};
    wr_mask  = 8'h0F;
    wr_data  = {32'hFFFFFFFF, 32'hCAFEF00D};
    rd_valid = 2'b00;
    #1;
    chk("da_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("da_rsp_data", rsp_data, 32'hC0DE0022);
    chk("zm_wr_ready", 32'(wr_ready), 32'h2);
    chk("zm_csb_w", 32'(csb_w), 32'h0);
    chk("zm_wmask", 32'(wmask), 32'h0);

    @(negedge clk);
    wr_valid = 2'b00;
    rd_valid = 2'b01;
    rd_addr  = {8'h40, 8'h21};
    #1;
    chk("rb_rd_ready", 32'(rd_ready), 32'h1);

    @(negedge clk);
    rd_valid = 2'b00;
    #1;
    chk("rb_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rb_rsp_data", rsp_data, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
